// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
//  - opcode / funct encodings of the supported instruction subset
//  - FSM state encoding (S_IF..S_WB, exported on the debug 'state' port)
//  - instruction class enum latched in S_ID
//  - select / ALU control encodings driven onto the datapath
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_IMM = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_LUI = 3'd5,
    CLS_J   = 3'd6,
    CLS_ILL = 3'd7
  } cls_t;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_JMP  = 2'b01;
  localparam logic [1:0] NPC_BR   = 2'b11;

  localparam logic [1:0] EXT_LUI  = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_IMM   = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//  i_op    : IR[31:26]
//  i_funct : IR[5:0]
//  o_cls   : instruction class (CLS_ILL for anything unsupported)
//  o_sub   : R-type subtract (only meaningful when o_cls == CLS_R)
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_sub
);

  always_comb begin
    o_cls = CLS_ILL;
    o_sub = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        if (i_funct == FN_ADD) begin
          o_cls = CLS_R;
        end else if (i_funct == FN_SUB) begin
          o_cls = CLS_R;
          o_sub = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU: o_cls = CLS_IMM;
      OP_LW:             o_cls = CLS_LW;
      OP_SW:             o_cls = CLS_SW;
      OP_BEQ:            o_cls = CLS_BEQ;
      OP_LUI:            o_cls = CLS_LUI;
      OP_J:              o_cls = CLS_J;
      default:           o_cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS subset datapath
// (add, sub, addi, addiu, lw, sw, beq, lui, j).
// Walks each instruction through IF/ID/EXE/MEM/WB, stalls on the
// instruction/data memory ready inputs and counts retired instructions.
//
// Ports:
//  clk, rst (async, active-low)
//  op, funct        : IR fields, valid from S_ID onward
//  beqout           : ALU zero flag, used in S_EXE of beq
//  imem_rdy         : instruction fetch data valid (looked at only in S_IF)
//  dmem_rdy         : data access complete (looked at only in S_MEM)
//  pc_wr, ir_wr     : PC / IR load enables
//  npc_sel          : next-PC source
//  DMWrite, dmem_req: data memory write strobe / request
//  RegWrt           : register file write enable (one cycle, S_WB)
//  ExtOp, ALUctr, mux4_5sel, mux4_32sel, mux2sel : datapath selects
//  state            : current FSM state (debug)
//  retired          : instructions completed since reset (wraps)
//
// Handshake: imem_rdy / dmem_rdy act as "ready" for a request the FSM
// holds continuously (fetch in S_IF, dmem_req in S_MEM). The transfer
// completes in the cycle the ready input is high; the FSM advances on
// that clock edge and never drops the request before then.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             beqout,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_sel,
  output logic             DMWrite,
  output logic             dmem_req,
  output logic             RegWrt,
  output logic [1:0]       ExtOp,
  output logic [2:0]       ALUctr,
  output logic [1:0]       mux4_5sel,
  output logic [1:0]       mux4_32sel,
  output logic             mux2sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  logic             r_sub;
  cls_t             w_cls;
  logic             w_sub;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  mc_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls),
    .o_sub   (w_sub)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Class is captured once in S_ID so EXE/MEM/WB selects stay stable even
  // if the IR fields wobble later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cls <= CLS_ILL;
      r_sub <= 1'b0;
    end else if (r_state == S_ID) begin
      r_cls <= w_cls;
      r_sub <= w_sub;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    npc_sel    = NPC_SEQ;
    DMWrite    = 1'b0;
    dmem_req   = 1'b0;
    RegWrt     = 1'b0;
    ExtOp      = EXT_LUI;
    ALUctr     = ALU_IDLE;
    mux4_5sel  = DST_RT;
    mux4_32sel = WB_ALU;
    mux2sel    = 1'b0;

    // Datapath selects come from the latched class and are held from EXE
    // through WB so the ALU result and writeback path never glitch.
    if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
      case (r_cls)
        CLS_R: begin
          ALUctr    = r_sub ? ALU_SUB : ALU_ADD;
          mux4_5sel = DST_RD;
        end
        CLS_IMM, CLS_SW: begin
          ExtOp   = EXT_SIGN;
          ALUctr  = ALU_ADD;
          mux2sel = 1'b1;
        end
        CLS_LW: begin
          ExtOp      = EXT_SIGN;
          ALUctr     = ALU_ADD;
          mux2sel    = 1'b1;
          mux4_32sel = WB_MEM;
        end
        CLS_BEQ: ALUctr = ALU_SUB;
        CLS_LUI: mux4_32sel = WB_IMM;
        default: ;
      endcase
    end

    case (r_state)
      S_IF: begin
        // Gated by rst so no PC/IR load can escape while reset is held.
        pc_wr = imem_rdy & rst;
        ir_wr = imem_rdy & rst;
        if (imem_rdy) w_next = S_ID;
      end
      S_ID: begin
        case (w_cls)
          CLS_J: begin
            pc_wr    = 1'b1;
            npc_sel  = NPC_JMP;
            w_retire = 1'b1;
            w_next   = S_IF;
          end
          CLS_ILL: begin
            w_retire = 1'b1;
            w_next   = S_IF;
          end
          default: w_next = S_EXE;
        endcase
      end
      S_EXE: begin
        case (r_cls)
          CLS_BEQ: begin
            // PC already holds PC+4 from IF; a taken branch overrides it.
            pc_wr    = beqout;
            npc_sel  = beqout ? NPC_BR : NPC_SEQ;
            w_retire = 1'b1;
            w_next   = S_IF;
          end
          CLS_LW, CLS_SW:            w_next = S_MEM;
          CLS_R, CLS_IMM, CLS_LUI:   w_next = S_WB;
          default:                   w_next = S_IF;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        DMWrite  = (r_cls == CLS_SW);
        if (dmem_rdy) begin
          if (r_cls == CLS_SW) begin
            w_retire = 1'b1;
            w_next   = S_IF;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrt   = 1'b1;
        w_retire = 1'b1;
        w_next   = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: drives instructions cycle by cycle, pushes the
// expected output vector of every cycle to exp_q and a negedge monitor pops
// and compares it against the DUT outputs. Counter width is shrunk so the
// retired counter wraps within the run.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  // Encodings written out independently of the design package.
  localparam logic [5:0] T_OP_R = 6'b000000, T_OP_J = 6'b000010, T_OP_BEQ = 6'b000100;
  localparam logic [5:0] T_OP_ADDI = 6'b001000, T_OP_ADDIU = 6'b001001, T_OP_LUI = 6'b001111;
  localparam logic [5:0] T_OP_LW = 6'b100011, T_OP_SW = 6'b101011;
  localparam logic [5:0] T_FN_ADD = 6'b100000, T_FN_SUB = 6'b100010;
  localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_LUI = 5, K_J = 6, K_ILL = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op, funct;
  logic          beqout, imem_rdy, dmem_rdy;
  logic          pc_wr, ir_wr, DMWrite, dmem_req, RegWrt, mux2sel;
  logic [1:0]    npc_sel, ExtOp, mux4_5sel, mux4_32sel;
  logic [2:0]    ALUctr, state;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .beqout(beqout),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .pc_wr(pc_wr), .ir_wr(ir_wr),
    .npc_sel(npc_sel), .DMWrite(DMWrite), .dmem_req(dmem_req), .RegWrt(RegWrt),
    .ExtOp(ExtOp), .ALUctr(ALUctr), .mux4_5sel(mux4_5sel), .mux4_32sel(mux4_32sel),
    .mux2sel(mux2sel), .state(state), .retired(retired)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ret = 0;
  logic        mon_en  = 1'b0;
  string       cur_tag = "idle";

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  wire [23:0] w_obs = {state, pc_wr, ir_wr, npc_sel, DMWrite, dmem_req, RegWrt,
                       ExtOp, ALUctr, mux4_5sel, mux4_32sel, mux2sel, retired};

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check_eq({cur_tag, ".queue_empty"}, exp_q.size(), 1);
      end else begin
        check_eq(cur_tag, w_obs, exp_q.pop_front());
      end
    end
  end

  // Selects {ExtOp, ALUctr, mux4_5sel, mux4_32sel, mux2sel} for each class.
  function automatic logic [9:0] sel_bits(input int c, input logic sub);
    case (c)
      K_R:          return {2'b00, (sub ? 3'b010 : 3'b001), 2'b01, 2'b00, 1'b0};
      K_IMM, K_SW:  return {2'b10, 3'b001, 2'b00, 2'b00, 1'b1};
      K_LW:         return {2'b10, 3'b001, 2'b00, 2'b01, 1'b1};
      K_BEQ:        return {2'b00, 3'b010, 2'b00, 2'b00, 1'b0};
      K_LUI:        return {2'b00, 3'b000, 2'b00, 2'b11, 1'b0};
      default:      return 10'b0;
    endcase
  endfunction

  function automatic logic [23:0] mk(input logic [2:0] st, input logic pc, input logic ir,
                                     input logic [1:0] npc, input logic dmw, input logic dreq,
                                     input logic regw, input logic sel_on, input int c,
                                     input logic sub);
    logic [CW-1:0] r;
    r = CW'(exp_ret);
    return {st, pc, ir, npc, dmw, dreq, regw, (sel_on ? sel_bits(c, sub) : 10'b0), r};
  endfunction

  function automatic int tb_cls(input logic [5:0] o, input logic [5:0] f);
    case (o)
      T_OP_R:               return (f == T_FN_ADD || f == T_FN_SUB) ? K_R : K_ILL;
      T_OP_ADDI, T_OP_ADDIU: return K_IMM;
      T_OP_LW:              return K_LW;
      T_OP_SW:              return K_SW;
      T_OP_BEQ:             return K_BEQ;
      T_OP_LUI:             return K_LUI;
      T_OP_J:               return K_J;
      default:              return K_ILL;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic bq, input int iw, input int mw);
    int   c;
    logic sub;
    c   = tb_cls(o, f);
    sub = (o == T_OP_R) && (f == T_FN_SUB);
    op = o; funct = f; beqout = bq;
    for (int i = 0; i <= iw; i++) begin
      imem_rdy = (i == iw);
      cur_tag  = {nm, ".IF"};
      exp_q.push_back(mk(3'd0, imem_rdy, imem_rdy, 2'b00, 0, 0, 0, 0, c, sub));
      step();
    end
    imem_rdy = 1'b0;
    cur_tag  = {nm, ".ID"};
    if (c == K_J) begin
      exp_q.push_back(mk(3'd1, 1, 0, 2'b01, 0, 0, 0, 0, c, sub));
      exp_ret++; step(); return;
    end
    exp_q.push_back(mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, c, sub));
    if (c == K_ILL) begin
      exp_ret++; step(); return;
    end
    step();
    cur_tag = {nm, ".EXE"};
    if (c == K_BEQ) begin
      exp_q.push_back(mk(3'd2, bq, 0, (bq ? 2'b11 : 2'b00), 0, 0, 0, 1, c, sub));
      exp_ret++; step(); return;
    end
    exp_q.push_back(mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 1, c, sub));
    step();
    if (c == K_LW || c == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        dmem_rdy = (i == mw);
        cur_tag  = {nm, ".MEM"};
        exp_q.push_back(mk(3'd3, 0, 0, 2'b00, (c == K_SW), 1, 0, 1, c, sub));
        if (dmem_rdy && c == K_SW) exp_ret++;
        step();
      end
      dmem_rdy = 1'b0;
      if (c == K_SW) return;
    end
    cur_tag = {nm, ".WB"};
    exp_q.push_back(mk(3'd4, 0, 0, 2'b00, 0, 0, 1, 1, c, sub));
    exp_ret++;
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] r_ops [9];
  logic [5:0] r_fns [9];

  initial begin
    rst = 1'b0; op = '0; funct = '0; beqout = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    // Reset held with imem_rdy high: no load enable may escape.
    for (int i = 0; i < 2; i++) begin
      imem_rdy = 1'b1;
      cur_tag  = "reset";
      exp_q.push_back(mk(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, K_ILL, 0));
      step();
    end
    rst = 1'b1; imem_rdy = 1'b0;

    run_instr("add",      T_OP_R,     T_FN_ADD, 0, 0, 0);
    run_instr("sub",      T_OP_R,     T_FN_SUB, 0, 0, 0);
    run_instr("addi",     T_OP_ADDI,  6'h15,    0, 0, 0);
    run_instr("addiu",    T_OP_ADDIU, 6'h3f,    0, 1, 0);
    run_instr("lui",      T_OP_LUI,   6'h00,    1, 0, 0);
    run_instr("lw_stall", T_OP_LW,    6'h04,    0, 0, 3);
    run_instr("beq_tk",   T_OP_BEQ,   6'h00,    1, 0, 0);
    run_instr("beq_nt",   T_OP_BEQ,   6'h00,    0, 0, 0);
    run_instr("j",        T_OP_J,     6'h00,    1, 0, 0);
    run_instr("sw_stall", T_OP_SW,    6'h08,    0, 2, 2);
    run_instr("ill_op",   6'b111111,  6'h20,    0, 0, 0);
    run_instr("ill_fn",   T_OP_R,     6'b100100, 0, 0, 0);

    // Reset in the middle of a stalled lw.
    op = T_OP_LW; funct = 6'h00;
    cur_tag = "rst_lw.IF";  imem_rdy = 1'b1;
    exp_q.push_back(mk(3'd0, 1, 1, 2'b00, 0, 0, 0, 0, K_LW, 0)); step();
    imem_rdy = 1'b0;
    cur_tag = "rst_lw.ID";  exp_q.push_back(mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, K_LW, 0)); step();
    cur_tag = "rst_lw.EXE"; exp_q.push_back(mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 1, K_LW, 0)); step();
    cur_tag = "rst_lw.MEM"; exp_q.push_back(mk(3'd3, 0, 0, 2'b00, 0, 1, 0, 1, K_LW, 0)); step();
    rst = 1'b0; imem_rdy = 1'b1;
    #1;
    check_eq("rst_async_state", state, 0);
    check_eq("rst_async_retired", retired, 0);
    exp_ret = 0;
    for (int i = 0; i < 2; i++) begin
      cur_tag = "rst_lw.held";
      dmem_rdy = (i == 1);
      exp_q.push_back(mk(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, K_LW, 0));
      step();
    end
    rst = 1'b1; imem_rdy = 1'b0; dmem_rdy = 1'b0;
    run_instr("add_post_rst", T_OP_R, T_FN_ADD, 0, 0, 0);

    // Random mix; long enough for the retired counter to wrap.
    r_ops = '{T_OP_R, T_OP_R, T_OP_ADDI, T_OP_ADDIU, T_OP_LW, T_OP_SW, T_OP_BEQ, T_OP_LUI, T_OP_J};
    r_fns = '{T_FN_ADD, T_FN_SUB, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07};
    for (int n = 0; n < 24; n++) begin
      int k;
      k = int'($urandom_range(0, 8));
      run_instr("rand", r_ops[k], r_fns[k], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    mon_en = 1'b0;
    check_eq("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
